lsu_regfile_client: RTL
=======================

Name: lsu_regfile_client

Overview:
- Load/store unit for one GPU core.
- Drives the core register file as an initiator: reads base and store-data registers, writes load results back.
- Bridges a single in-flight request onto a valid/ready memory request channel with a separate response channel.
- One LSU per core, instanced next to the per-core register file; data/address widths match it.

Parameters:
DATA_WIDTH, 8, width of register and memory data
ADDR_WIDTH, 8, width of memory address
REG_ADDR_WIDTH, 2, register index width (4 registers)
TIMEOUT_CYCLES, 16, abort threshold when LSU_TIMEOUT_EN is defined

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 forces all state to reset values immediately
start  input  1  request strobe; accepted only in IDLE
is_store  input  1  1=store, 0=load; sampled with start
rs_base  input  REG_ADDR_WIDTH  register holding base address; sampled with start
rs_data  input  REG_ADDR_WIDTH  register holding store data; sampled with start
rd  input  REG_ADDR_WIDTH  load destination register; sampled with start
imm  input  ADDR_WIDTH  address offset; sampled with start
rf_raddr1  output  REG_ADDR_WIDTH  register file read address 1 (= latched rs_base)
rf_raddr2  output  REG_ADDR_WIDTH  register file read address 2 (= latched rs_data)
rf_rdata1  input  DATA_WIDTH  combinational read data for rf_raddr1
rf_rdata2  input  DATA_WIDTH  combinational read data for rf_raddr2
rf_wen  output  1  register file write enable
rf_waddr  output  REG_ADDR_WIDTH  register file write address
rf_wdata  output  DATA_WIDTH  register file write data
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory request ready
mem_req_we  output  1  1=write request
mem_req_addr  output  ADDR_WIDTH  request address
mem_req_wdata  output  DATA_WIDTH  store data
mem_rsp_valid  input  1  load response valid, single cycle
mem_rsp_data  input  DATA_WIDTH  load response data
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at operation completion
error  output  1  sticky timeout flag; 0 when LSU_TIMEOUT_EN undefined

Behaviour:
- Reset values: all outputs 0; state IDLE; latched fields 0.
- States: IDLE, READ, REQ, WAIT, WB, DONE.
- IDLE: start=1 latches is_store/rs_base/rs_data/rd/imm -> READ. Clears error.
- start while busy: ignored, no effect on latched fields.
- READ (1 cycle): rf_raddr1/2 already driven from latched fields.
  - addr = (rf_rdata1 zero-extended/truncated to ADDR_WIDTH) + imm, modulo 2^ADDR_WIDTH, wrap silently.
  - wdata = rf_rdata2.
  - Both registered -> REQ.
- REQ: mem_req_valid=1; mem_req_we/addr/wdata held stable until handshake (valid & ready on one rising edge).
  - Store: -> DONE. No response expected; mem_rsp_valid ignored.
  - Load: -> WAIT.
- WAIT: mem_rsp_valid=1 captures mem_rsp_data -> WB. A response in the handshake cycle itself is ignored; earliest accepted response is the first WAIT cycle.
- WB (1 cycle): rf_wen=1, rf_waddr=rd, rf_wdata=captured data -> DONE.
- DONE (1 cycle): done=1 -> IDLE. start in DONE is ignored.
- mem_rsp_valid in any state other than WAIT: ignored.
- Latency with ready and response immediate:
  - Store: start@0, READ@1, REQ@2, done@3.
  - Load: start@0, READ@1, REQ@2, rsp@3, rf_wen@4, done@5.
- Load with rd == rs_base: legal. The base was already consumed in READ; writeback overwrites it.
- Reset asserted mid-operation: immediate return to IDLE; mem_req_valid and rf_wen drop asynchronously; no partial writeback.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter, clog2(TIMEOUT_CYCLES+1) bits, clears on entering REQ and on REQ->WAIT.
  - It increments each cycle spent in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: -> DONE, error=1, mem_req_valid dropped, no rf_wen.
  - error holds until the next accepted start or reset.
- Undefined: no counter; REQ/WAIT wait indefinitely; error tied 0.

Test Plan:
- Reg R3=2, imm=5, load, rd=1, ready=1, rsp data 0xA5 one cycle after handshake -> mem_req_addr=0x07, we=0; rf_wen@4 with waddr=1, wdata=0xA5; done@5.
- Store, R0=0x10, R2=0x3C, imm=0xF8 -> addr=0x08 (wrap), wdata=0x3C, we=1; done 1 cycle after handshake; rf_wen never asserted.
- mem_req_ready low 4 cycles -> valid/addr/wdata stable throughout; busy=1; completes after ready.
- start pulsed in REQ, WAIT, and DONE; stray mem_rsp_valid in IDLE -> no state change, no rf_wen, latched fields unchanged.
- reset driven low during WAIT -> busy/mem_req_valid/rf_wen=0 immediately; later response causes no writeback.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> after 16 WAIT cycles done=1, error=1, no rf_wen; next start clears error.

Source files
------------

// File: rtl/lsu_regfile_client.sv
// lsu_regfile_client: load/store unit for one GPU core.
//
// Reads a base register and a store-data register from the core register
// file, forms addr = base + imm, issues one request on a valid/ready memory
// channel and, for loads, writes the single-cycle response back to rd.
// Exactly one operation is in flight at a time.
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   start/is_store/rs_base/rs_data/rd/imm      : request, accepted only in IDLE
//   rf_raddr1/2, rf_rdata1/2                   : register file read ports
//   rf_wen/rf_waddr/rf_wdata                   : register file write port
//   mem_req_valid/ready/we/addr/wdata          : memory request channel
//   mem_rsp_valid/mem_rsp_data                 : memory response (loads only)
//   busy, done (1-cycle pulse), error (sticky timeout flag)
//
// Optional feature: define LSU_TIMEOUT_EN to abort an operation that spends
// TIMEOUT_CYCLES consecutive cycles in REQ or WAIT; error is tied low otherwise.
module lsu_regfile_client #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [REG_ADDR_WIDTH-1:0] rs_base,
    input  logic [REG_ADDR_WIDTH-1:0] rs_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [ADDR_WIDTH-1:0]     imm,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr1,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0]     rf_rdata1,
    input  logic [DATA_WIDTH-1:0]     rf_rdata2,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_we,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_REQ, S_WAIT, S_WB, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      is_store_q, is_store_d;
    logic [REG_ADDR_WIDTH-1:0] rs_base_q, rs_base_d;
    logic [REG_ADDR_WIDTH-1:0] rs_data_q, rs_data_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]     imm_q, imm_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      req_valid_q, req_valid_d;
    logic                      rf_wen_q, rf_wen_d;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             timeout_hit;
    logic             error_q, error_d;

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        rs_base_d  = rs_base_q;
        rs_data_d  = rs_data_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
        error_d    = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    rs_base_d  = rs_base;
                    rs_data_d  = rs_data;
                    rd_d       = rd;
                    imm_d      = imm;
                    state_d    = S_READ;
`ifdef LSU_TIMEOUT_EN
                    error_d    = 1'b0;
`endif
                end
            end
            S_READ: begin
                // Base is zero-extended or truncated to the address width;
                // the sum wraps modulo 2^ADDR_WIDTH.
                addr_d  = ADDR_WIDTH'(rf_rdata1) + imm_q;
                wdata_d = rf_rdata2;
                state_d = S_REQ;
`ifdef LSU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_REQ: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (mem_req_ready) begin
                    state_d = is_store_q ? S_DONE : S_WAIT;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
`endif
                end
            end
            S_WAIT: begin
`ifdef LSU_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_data;
                    state_d = S_WB;
`ifdef LSU_TIMEOUT_EN
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
`endif
                end
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        req_valid_d = (state_d == S_REQ);
        rf_wen_d    = (state_d == S_WB);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            rs_base_q   <= '0;
            rs_data_q   <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_valid_q <= 1'b0;
            rf_wen_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            rs_base_q   <= rs_base_d;
            rs_data_q   <= rs_data_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_valid_q <= req_valid_d;
            rf_wen_q    <= rf_wen_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= cnt_d;
            error_q     <= error_d;
`endif
        end
    end

    assign rf_raddr1     = rs_base_q;
    assign rf_raddr2     = rs_data_q;
    assign rf_wen        = rf_wen_q;
    assign rf_waddr      = rd_q;
    assign rf_wdata      = rdata_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = is_store_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef LSU_TIMEOUT_EN
    assign error         = error_q;
`else
    assign error         = 1'b0;
`endif

endmodule
